// File: rtl/control_sequencer.sv
// Five-state instruction sequencer for a 4-bit accumulator machine.
// Each instruction runs FETCH -> DECODE -> EXEC; opcode F parks the block in HALT until reset.
module control_sequencer #(
    parameter logic [3:0] PC_RESET = 4'h0
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic       start,
    input  logic [7:0] instr,
    input  logic       zero_flag,
    output logic [3:0] pc,
    output logic [3:0] operand,
    output logic       acc_en,
    output logic       acc_clr,
    output logic [1:0] alu_op,
    output logic       mem_we,
    output logic       busy,
    output logic       halted
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_HALT   = 3'd4
    } state_t;

    localparam logic [3:0] OP_LDI   = 4'h1;
    localparam logic [3:0] OP_ADD   = 4'h2;
    localparam logic [3:0] OP_SUB   = 4'h3;
    localparam logic [3:0] OP_AND   = 4'h4;
    localparam logic [3:0] OP_STORE = 4'h5;
    localparam logic [3:0] OP_JMP   = 4'h6;
    localparam logic [3:0] OP_JZ    = 4'h7;
    localparam logic [3:0] OP_CLRA  = 4'h8;
    localparam logic [3:0] OP_HALT  = 4'hF;

    state_t     state_r;
    logic [7:0] ir_r;
    logic [3:0] opcode_s;

    assign opcode_s = ir_r[7:4];
    assign operand  = ir_r[3:0];

    // Sequencer state, IR, pc and registered strobes/status.
    // Strobes are armed on the DECODE->EXEC edge so they are high exactly during EXEC.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_r <= ST_IDLE;
            ir_r    <= 8'h00;
            pc      <= PC_RESET;
            acc_en  <= 1'b0;
            acc_clr <= 1'b0;
            alu_op  <= 2'b00;
            mem_we  <= 1'b0;
            busy    <= 1'b0;
            halted  <= 1'b0;
        end else begin
            acc_en  <= 1'b0;
            acc_clr <= 1'b0;
            alu_op  <= 2'b00;
            mem_we  <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        state_r <= ST_FETCH;
                        busy    <= 1'b1;
                    end else begin
                        state_r <= ST_IDLE;
                        busy    <= 1'b0;
                    end
                    halted <= 1'b0;
                end
                ST_FETCH: begin
                    ir_r    <= instr;
                    pc      <= pc + 4'h1;
                    state_r <= ST_DECODE;
                end
                ST_DECODE: begin
                    if (opcode_s == OP_HALT) begin
                        state_r <= ST_HALT;
                        busy    <= 1'b0;
                        halted  <= 1'b1;
                    end else begin
                        state_r <= ST_EXEC;
                        case (opcode_s)
                            OP_LDI:   begin acc_en <= 1'b1; alu_op <= 2'b00; end
                            OP_ADD:   begin acc_en <= 1'b1; alu_op <= 2'b01; end
                            OP_SUB:   begin acc_en <= 1'b1; alu_op <= 2'b10; end
                            OP_AND:   begin acc_en <= 1'b1; alu_op <= 2'b11; end
                            OP_STORE: mem_we  <= 1'b1;
                            OP_CLRA:  acc_clr <= 1'b1;
                            default:  acc_en  <= 1'b0;
                        endcase
                    end
                end
                ST_EXEC: begin
                    state_r <= ST_FETCH;
                    // zero_flag is only looked at here, for a JZ
                    case (opcode_s)
                        OP_JMP:  pc <= ir_r[3:0];
                        OP_JZ:   pc <= zero_flag ? ir_r[3:0] : pc;
                        default: pc <= pc;
                    endcase
                end
                ST_HALT: begin
                    state_r <= ST_HALT;
                    busy    <= 1'b0;
                    halted  <= 1'b1;
                end
                default: begin
                    state_r <= ST_IDLE;
                    busy    <= 1'b0;
                    halted  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_control_sequencer.sv
// Randomized and directed bench for control_sequencer against an instruction-level model.
module tb_control_sequencer;

    logic       CLK = 1'b0;
    logic       RST_N = 1'b0;
    logic       start = 1'b0;
    logic [7:0] instr;
    logic       zero_flag = 1'b0;
    logic [3:0] pc, operand;
    logic       acc_en, acc_clr, mem_we, busy, halted;
    logic [1:0] alu_op;

    logic [7:0] mem [16];
    logic [3:0] m_pc;
    int         zf_force = -1;
    int         n_checks = 0;
    int         n_fail = 0;

    control_sequencer #(.PC_RESET(4'h0)) dut (
        .CLK(CLK), .RST_N(RST_N), .start(start), .instr(instr),
        .zero_flag(zero_flag), .pc(pc), .operand(operand),
        .acc_en(acc_en), .acc_clr(acc_clr), .alu_op(alu_op),
        .mem_we(mem_we), .busy(busy), .halted(halted)
    );

    assign instr = mem[pc];

    always #5 CLK = ~CLK;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Packed view {acc_en, acc_clr, mem_we, alu_op, busy, halted}
    function automatic logic [6:0] outs();
        return {acc_en, acc_clr, mem_we, alu_op, busy, halted};
    endfunction

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic drive_zf();
        zero_flag = (zf_force < 0) ? 1'($urandom % 2) : zf_force[0];
    endtask

    task automatic do_reset();
        @(posedge CLK);
        #1;
        RST_N = 1'b0;
        start = 1'b0;
        #2;
        check_eq("reset_pc", {28'd0, pc}, 32'h0);
        check_eq("reset_outs", {25'd0, outs()}, 32'h0);
        check_eq("reset_operand", {28'd0, operand}, 32'h0);
        #2;
        RST_N = 1'b1;
        m_pc = 4'h0;
        step();
        step();
        check_eq("idle_hold", {25'd0, outs()}, 32'h0);
    endtask

    task automatic start_prog();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    // Model one instruction starting in its FETCH cycle; returns 1 if it was HALT.
    task automatic run_instr(output bit was_halt);
        logic [7:0] w;
        logic [3:0] op;
        logic [6:0] exp_o;
        bit         is_alu;
        w  = mem[m_pc];
        op = w[7:4];
        check_eq("fetch_pc", {28'd0, pc}, {28'd0, m_pc});
        check_eq("fetch_outs", {25'd0, outs()}, {25'd0, 7'b0000010});
        drive_zf();
        step();
        m_pc = m_pc + 4'h1;
        check_eq("decode_pc", {28'd0, pc}, {28'd0, m_pc});
        check_eq("decode_operand", {28'd0, operand}, {28'd0, w[3:0]});
        check_eq("decode_outs", {25'd0, outs()}, {25'd0, 7'b0000010});
        drive_zf();
        step();
        if (op == 4'hF) begin
            check_eq("halt_outs", {25'd0, outs()}, {25'd0, 7'b0000001});
            was_halt = 1'b1;
            return;
        end
        is_alu = (op >= 4'h1) && (op <= 4'h4);
        exp_o = {is_alu, op == 4'h8, op == 4'h5,
                 is_alu ? 2'(op - 4'h1) : 2'b00, 1'b1, 1'b0};
        check_eq("exec_outs", {25'd0, outs()}, {25'd0, exp_o});
        check_eq("exec_pc", {28'd0, pc}, {28'd0, m_pc});
        check_eq("exec_operand", {28'd0, operand}, {28'd0, w[3:0]});
        drive_zf();
        if (op == 4'h6 || (op == 4'h7 && zero_flag))
            m_pc = w[3:0];
        step();
        was_halt = 1'b0;
    endtask

    task automatic halt_ignores_start();
        logic [3:0] hold_pc;
        hold_pc = pc;
        start = 1'b1;
        repeat (3) step();
        start = 1'b0;
        step();
        check_eq("halt_sticky", {25'd0, outs()}, {25'd0, 7'b0000001});
        check_eq("halt_pc", {28'd0, pc}, {28'd0, hold_pc});
    endtask

    initial begin
        bit h;
        for (int i = 0; i < 16; i++) mem[i] = 8'h00;
        m_pc = 4'h0;
        #12;
        do_reset();

        // LDI 5 then HALT
        mem[0] = 8'h15; mem[1] = 8'hF0;
        start_prog();
        run_instr(h);
        run_instr(h);
        check_eq("ldi_then_halt", {31'd0, h}, 32'h1);
        halt_ignores_start();

        // LDI 3, ADD 2, STORE 7, CLRA, SUB 1, AND 6, HALT
        do_reset();
        mem[0] = 8'h13; mem[1] = 8'h22; mem[2] = 8'h57; mem[3] = 8'h80;
        mem[4] = 8'h31; mem[5] = 8'h46; mem[6] = 8'hF0;
        start_prog();
        for (int i = 0; i < 7; i++) run_instr(h);
        check_eq("seq_halt", {31'd0, h}, 32'h1);

        // JZ 9 not taken, then taken
        do_reset();
        mem[0] = 8'h79; mem[1] = 8'h79; mem[9] = 8'hF0;
        start_prog();
        zf_force = 0;
        run_instr(h);
        check_eq("jz_not_taken", {28'd0, pc}, 32'h1);
        zf_force = 1;
        run_instr(h);
        check_eq("jz_taken", {28'd0, pc}, 32'h9);
        zf_force = -1;
        run_instr(h);
        check_eq("jz_halt", {31'd0, h}, 32'h1);

        // pc wrap: JMP F, NOP at F, back to 0
        do_reset();
        for (int i = 0; i < 16; i++) mem[i] = 8'h00;
        mem[0] = 8'h6F; mem[15] = 8'h00;
        start_prog();
        run_instr(h);
        check_eq("jmp_f", {28'd0, pc}, 32'hF);
        run_instr(h);
        check_eq("pc_wrap", {28'd0, pc}, 32'h0);

        // Reset during ADD EXEC
        do_reset();
        mem[0] = 8'h13; mem[1] = 8'h22;
        start_prog();
        run_instr(h);
        step();
        step();
        check_eq("pre_abort", {25'd0, outs()}, {25'd0, 7'b1000110});
        #2;
        RST_N = 1'b0;
        #1;
        check_eq("abort_outs", {25'd0, outs()}, 32'h0);
        check_eq("abort_pc", {28'd0, pc}, 32'h0);
        #3;
        RST_N = 1'b1;
        m_pc = 4'h0;
        repeat (3) step();
        check_eq("abort_idle", {25'd0, outs()}, 32'h0);
        check_eq("abort_idle_pc", {28'd0, pc}, 32'h0);

        // Random programs
        for (int p = 0; p < 8; p++) begin
            do_reset();
            for (int i = 0; i < 16; i++) mem[i] = 8'($urandom);
            start_prog();
            h = 1'b0;
            for (int k = 0; k < 40 && !h; k++) run_instr(h);
            if (h) halt_ignores_start();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
